noc_dfd_tracer: RTL and testbench
=================================

NOC_DFD_TRACER -- requirements
Module: noc_dfd_tracer

Interface
REQ-001 SHALL have parameter NE, default 16, meaning the number of endpoints observed.
REQ-002 SHALL have parameter Fw, default 38, meaning the flit width per endpoint.
REQ-003 SHALL have parameter TRACE_W, default 32, meaning the trace word width, with TRACE_W <= Fw.
REQ-004 SHALL have parameter DEPTH, default 16, meaning the trace FIFO depth, a power of two >= 2.
REQ-005 SHALL have parameter CNTw, default 8, meaning the post-trigger counter width.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 SHALL have port flit_in_all, input, NE*Fw bits, the observed flits; endpoint i occupies bits [i*Fw +: Fw].
REQ-009 SHALL have port flit_in_wr_all, input, NE bits, the per-endpoint flit valid.
REQ-010 SHALL have port cfg_sel, input, log2(NE) bits (minimum 1), the observed endpoint index.
REQ-011 SHALL have port cfg_mode, input, 2 bits: 0 = OFF, 1 = CONTINUOUS, 2 = START_ON_TRIG, 3 = STOP_AFTER_TRIG.
REQ-012 SHALL have port cfg_match_val, input, TRACE_W bits, the trigger compare value.
REQ-013 SHALL have port cfg_match_mask, input, TRACE_W bits, the trigger compare mask; 1 = bit compared.
REQ-014 SHALL have port cfg_post_cnt, input, CNTw bits, the number of words captured after the trigger in mode 3.
REQ-015 SHALL have port arm, input, 1 bit, a single-cycle pulse that starts a session.
REQ-016 SHALL have port rd_en, input, 1 bit, the FIFO pop request.
REQ-017 SHALL have port trigger, output, 1 bit, a one-cycle pulse on a trigger match.
REQ-018 SHALL have port trace, output, TRACE_W bits, the FIFO head word.
REQ-019 SHALL have port trace_valid, output, 1 bit, asserted when the FIFO is not empty.
REQ-020 SHALL have port full, output, 1 bit, asserted when the FIFO is full.
REQ-021 SHALL have port overflow, output, 1 bit, a sticky flag set when a word is dropped.
REQ-022 SHALL have port state, output, 2 bits: IDLE = 0, ARMED = 1, CAPTURE = 2, DONE = 3.

Function
REQ-023 SHALL form a sample as the low TRACE_W bits of the selected endpoint's flit, qualified by flit_in_wr_all[cfg_sel].
REQ-024 SHALL define match as: sample valid AND ((sample XOR cfg_match_val) AND cfg_match_mask) == 0; an all-zero mask matches any valid sample.
REQ-025 SHALL remain in IDLE and capture nothing while cfg_mode is 0; arm is ignored in mode 0.
REQ-026 SHALL move IDLE->ARMED on arm in modes 2 and 3, and IDLE->CAPTURE on arm in mode 1.
REQ-027 SHALL, in ARMED, pulse trigger on the cycle after a match and move to CAPTURE; the matching sample itself SHALL be written to the FIFO.
REQ-028 SHALL, in CAPTURE under modes 1 and 2, write every valid sample and stay in CAPTURE until the next arm or until cfg_mode is 0.
REQ-029 SHALL, in CAPTURE under mode 3, load a counter with cfg_post_cnt at the trigger, decrement it on each captured word, and enter DONE when the counter equals 0 at a valid sample; cfg_post_cnt = 0 SHALL capture only the trigger word.
REQ-030 SHALL hold in DONE without capturing until arm, which returns the block to IDLE semantics (same transitions as REQ-026), or until cfg_mode is 0, which returns it to IDLE.
REQ-031 SHALL treat arm asserted in any non-IDLE state as a restart: flush the FIFO, clear overflow and the counter, and apply REQ-026.
REQ-032 SHALL make the FIFO first-word-fall-through: trace is valid in the same cycle trace_valid is high; rd_en with an empty FIFO SHALL be ignored.
REQ-033 SHALL have a write-to-trace_valid latency of one cycle.
REQ-034 SHALL, on a simultaneous write and read with the FIFO full, accept both and keep the occupancy unchanged without setting overflow.
REQ-035 SHALL, on a write to a full FIFO without a read, drop the new word and set overflow.
REQ-036 SHALL use wrap-around pointers of log2(DEPTH)+1 bits; full SHALL mean the MSBs differ and the LSBs are equal.
REQ-037 SHALL not disturb the FIFO contents on a change of cfg_sel or cfg_mode; a change of cfg_mode to 0 SHALL stop capture only.

Reset
REQ-038 SHALL, on reset high at a clock edge, set state = IDLE, trigger = 0, trace_valid = 0, full = 0, overflow = 0, the pointers and counter to 0, and trace to 0.
REQ-039 SHALL give reset priority over arm, rd_en and sample writes, including in the middle of a capture.

Verification
REQ-040 SHALL verify: mode 1, NE = 4, cfg_sel = 2, arm, then 3 valid flits 0x11, 0x22, 0x33 on endpoint 2 -> FIFO reads 0x11, 0x22, 0x33, and endpoint-0 traffic is never captured.
REQ-041 SHALL verify: mode 2, mask = 0xFF, value = 0xA5, samples 0x01, 0xA5, 0x02 -> trigger pulses once, the FIFO holds 0xA5, 0x02, and state = CAPTURE.
REQ-042 SHALL verify: mode 3, cfg_post_cnt = 2, trigger on 0xA5 followed by 4 valid samples -> the FIFO holds exactly 3 words and state = DONE.
REQ-043 SHALL verify: DEPTH = 4, 5 writes with no reads -> full = 1, overflow = 1, and the FIFO holds the first 4 words; then read and write together while full -> overflow stays 1 and the occupancy stays 4.
REQ-044 SHALL verify: reset asserted mid-CAPTURE with 2 words stored -> the next cycle shows state = 0, trace_valid = 0, overflow = 0.
REQ-045 SHALL verify: arm pulsed in DONE with 3 words stored -> the FIFO is flushed and state = ARMED (mode 3).

Source files
------------

// File: rtl/noc_dfd_tracer.sv
// Debug trace tap for a NoC: selects one endpoint's flit stream, triggers on a
// masked compare and captures samples into a first-word-fall-through FIFO.
module noc_dfd_tracer #(
    parameter int NE      = 16,
    parameter int Fw      = 38,
    parameter int TRACE_W = 32,
    parameter int DEPTH   = 16,
    parameter int CNTw    = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NE*Fw-1:0]                    flit_in_all,
    input  logic [NE-1:0]                       flit_in_wr_all,
    input  logic [(NE > 1 ? $clog2(NE) : 1)-1:0] cfg_sel,
    input  logic [1:0]                          cfg_mode,
    input  logic [TRACE_W-1:0]                  cfg_match_val,
    input  logic [TRACE_W-1:0]                  cfg_match_mask,
    input  logic [CNTw-1:0]                     cfg_post_cnt,
    input  logic                                arm,
    input  logic                                rd_en,
    output logic                                trigger,
    output logic [TRACE_W-1:0]                  trace,
    output logic                                trace_valid,
    output logic                                full,
    output logic                                overflow,
    output logic [1:0]                          state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_CONT  = 2'd1,
        M_START = 2'd2,
        M_STOP  = 2'd3
    } mode_e;

    state_e               cur, nxt;
    mode_e                mode;
    logic [TRACE_W-1:0]   sample;
    logic                 sample_vld;
    logic                 match;
    logic                 wr_req, flush, load_cnt, dec_cnt, trig_next;
    logic [CNTw-1:0]      cnt;
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [TRACE_W-1:0]   mem [DEPTH];
    logic                 empty, full_i, do_rd, do_wr, drop;
    logic                 unused_flit_bits;

    assign mode = mode_e'(cfg_mode);

    // Only the low TRACE_W bits of each flit are traced.
    assign unused_flit_bits = ^flit_in_all;

    always_comb begin
        sample     = '0;
        sample_vld = 1'b0;
        for (int unsigned i = 0; i < NE; i++) begin
            if (i == 32'(cfg_sel)) begin
                sample     = flit_in_all[i*Fw +: TRACE_W];
                sample_vld = flit_in_wr_all[i];
            end
        end
    end

    assign match = sample_vld && (((sample ^ cfg_match_val) & cfg_match_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset) cur <= IDLE;
        else       cur <= nxt;
    end

    always_comb begin
        nxt       = cur;
        wr_req    = 1'b0;
        flush     = 1'b0;
        load_cnt  = 1'b0;
        dec_cnt   = 1'b0;
        trig_next = 1'b0;
        if (mode == M_OFF) begin
            nxt = IDLE;
        end else if (arm) begin
            flush = (cur != IDLE);
            nxt   = (mode == M_CONT) ? CAPTURE : ARMED;
        end else begin
            case (cur)
                ARMED: begin
                    if (match) begin
                        wr_req    = 1'b1;
                        trig_next = 1'b1;
                        load_cnt  = 1'b1;
                        nxt       = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (sample_vld) begin
                        if (mode == M_STOP) begin
                            // Counter holds the words still owed after the trigger word.
                            if (cnt == '0) begin
                                nxt = DONE;
                            end else begin
                                wr_req  = 1'b1;
                                dec_cnt = 1'b1;
                            end
                        end else begin
                            wr_req = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign empty  = (wr_ptr == rd_ptr);
    assign full_i = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd  = rd_en && !empty;
    assign do_wr  = wr_req && (!full_i || do_rd);
    assign drop   = wr_req && full_i && !do_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            cnt      <= '0;
            trigger  <= 1'b0;
        end else begin
            trigger <= trig_next;
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
                cnt      <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + 1'b1;
                if (do_rd) rd_ptr <= rd_ptr + 1'b1;
                if (drop)  overflow <= 1'b1;
                if (load_cnt)     cnt <= cfg_post_cnt;
                else if (dec_cnt) cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && do_wr) mem[wr_ptr[AW-1:0]] <= sample;
    end

    assign trace       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign trace_valid = !empty;
    assign full        = full_i;
    assign state       = cur;

endmodule

// File: tb/tb_noc_dfd_tracer.sv
// Directed self-checking bench for noc_dfd_tracer (NE=4, 8-bit trace, depth 4).
module tb_noc_dfd_tracer;

    localparam int NE = 4;
    localparam int FW = 12;
    localparam int TW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NE*FW-1:0] flit_in_all;
    logic [NE-1:0]    flit_in_wr_all;
    logic [1:0]       cfg_sel;
    logic [1:0]       cfg_mode;
    logic [TW-1:0]    cfg_match_val;
    logic [TW-1:0]    cfg_match_mask;
    logic [3:0]       cfg_post_cnt;
    logic             arm;
    logic             rd_en;
    logic             trigger;
    logic [TW-1:0]    trace;
    logic             trace_valid;
    logic             full;
    logic             overflow;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    noc_dfd_tracer #(.NE(NE), .Fw(FW), .TRACE_W(TW), .DEPTH(4), .CNTw(4)) dut (
        .clk(clk), .reset(reset),
        .flit_in_all(flit_in_all), .flit_in_wr_all(flit_in_wr_all),
        .cfg_sel(cfg_sel), .cfg_mode(cfg_mode),
        .cfg_match_val(cfg_match_val), .cfg_match_mask(cfg_match_mask),
        .cfg_post_cnt(cfg_post_cnt), .arm(arm), .rd_en(rd_en),
        .trigger(trigger), .trace(trace), .trace_valid(trace_valid),
        .full(full), .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flit_in_all    = '0;
        flit_in_wr_all = '0;
        arm            = 1'b0;
        rd_en          = 1'b0;
    endtask

    // Drives one valid flit on endpoint ep; upper flit bits are junk that must be ignored.
    task automatic flit(input int ep, input logic [7:0] d, input logic rd);
        flit_in_all              = '0;
        flit_in_wr_all           = '0;
        flit_in_all[ep*FW +: FW] = {4'hF, d};
        flit_in_wr_all[ep]       = 1'b1;
        rd_en                    = rd;
        step();
        clear_inputs();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_vld"}, 32'(trace_valid), 32'd1);
        check(tag, 32'(trace), 32'(exp));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        clear_inputs();
        cfg_sel        = 2'd2;
        cfg_mode       = 2'd0;
        cfg_match_val  = 8'hA5;
        cfg_match_mask = 8'hFF;
        cfg_post_cnt   = 4'd2;
        reset          = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(trace_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_trig", 32'(trigger), 32'd0);
        check("rst_trace", 32'(trace), 32'd0);

        // Mode 0: arm ignored, nothing captured
        pulse_arm();
        check("off_state", 32'(state), 32'd0);
        flit(2, 8'h5A, 1'b0);
        check("off_valid", 32'(trace_valid), 32'd0);

        // Continuous mode, endpoint 2 only
        cfg_mode = 2'd1;
        pulse_arm();
        check("cont_state", 32'(state), 32'd2);
        flit(0, 8'h99, 1'b0);
        check("cont_ep0_ignored", 32'(trace_valid), 32'd0);
        flit(2, 8'h11, 1'b0);
        check("cont_lat_vld", 32'(trace_valid), 32'd1);
        check("cont_lat_data", 32'(trace), 32'h11);
        flit(0, 8'h77, 1'b0);
        flit(2, 8'h22, 1'b0);
        flit(2, 8'h33, 1'b0);
        pop_check("cont_w0", 8'h11);
        pop_check("cont_w1", 8'h22);
        pop_check("cont_w2", 8'h33);
        check("cont_empty", 32'(trace_valid), 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("rd_empty_ignored", 32'(trace_valid), 32'd0);

        // Start-on-trigger
        cfg_mode = 2'd2;
        pulse_arm();
        check("sot_state_armed", 32'(state), 32'd1);
        flit(2, 8'h01, 1'b0);
        check("sot_no_trig", 32'(trigger), 32'd0);
        check("sot_no_cap", 32'(trace_valid), 32'd0);
        flit(2, 8'hA5, 1'b0);
        check("sot_trig", 32'(trigger), 32'd1);
        check("sot_state_cap", 32'(state), 32'd2);
        flit(2, 8'h02, 1'b0);
        check("sot_trig_once", 32'(trigger), 32'd0);
        pop_check("sot_w0", 8'hA5);
        pop_check("sot_w1", 8'h02);
        check("sot_empty", 32'(trace_valid), 32'd0);
        check("sot_state_end", 32'(state), 32'd2);

        // Stop-after-trigger, post count 2, then restart from DONE
        cfg_mode = 2'd3;
        pulse_arm();
        flit(2, 8'hA5, 1'b0);
        flit(2, 8'h10, 1'b0);
        flit(2, 8'h20, 1'b0);
        flit(2, 8'h30, 1'b0);
        flit(2, 8'h40, 1'b0);
        check("sat_state_done", 32'(state), 32'd3);
        check("sat_not_full", 32'(full), 32'd0);
        check("sat_vld", 32'(trace_valid), 32'd1);
        pulse_arm();
        check("restart_flush", 32'(trace_valid), 32'd0);
        check("restart_state", 32'(state), 32'd1);
        flit(2, 8'hA5, 1'b0);
        flit(2, 8'h10, 1'b0);
        flit(2, 8'h20, 1'b0);
        flit(2, 8'h30, 1'b0);
        flit(2, 8'h40, 1'b0);
        flit(2, 8'h50, 1'b0);
        pop_check("sat_w0", 8'hA5);
        pop_check("sat_w1", 8'h10);
        pop_check("sat_w2", 8'h20);
        check("sat_exactly3", 32'(trace_valid), 32'd0);

        // Overflow and full read+write
        cfg_mode = 2'd1;
        pulse_arm();
        flit(2, 8'h01, 1'b0);
        flit(2, 8'h02, 1'b0);
        flit(2, 8'h03, 1'b0);
        flit(2, 8'h04, 1'b0);
        check("ovf_full4", 32'(full), 32'd1);
        check("ovf_not_yet", 32'(overflow), 32'd0);
        flit(2, 8'h05, 1'b0);
        check("ovf_full5", 32'(full), 32'd1);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", 32'(trace), 32'h01);
        flit(2, 8'h06, 1'b1);
        check("rw_full", 32'(full), 32'd1);
        check("rw_ovf", 32'(overflow), 32'd1);
        pop_check("rw_w0", 8'h02);
        pop_check("rw_w1", 8'h03);
        pop_check("rw_w2", 8'h04);
        pop_check("rw_w3", 8'h06);
        check("rw_empty", 32'(trace_valid), 32'd0);

        // Reset in the middle of capture wins over arm, flit and read
        pulse_arm();
        check("rearm_ovf_clr", 32'(overflow), 32'd0);
        flit(2, 8'h0A, 1'b0);
        flit(2, 8'h0B, 1'b0);
        reset                     = 1'b1;
        arm                       = 1'b1;
        rd_en                     = 1'b1;
        flit_in_all[2*FW +: FW]   = 12'h0C;
        flit_in_wr_all[2]         = 1'b1;
        step();
        clear_inputs();
        reset = 1'b0;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_vld", 32'(trace_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_trace", 32'(trace), 32'd0);

        // Zero mask matches any valid sample; post count 0 keeps only the trigger word
        cfg_mode       = 2'd3;
        cfg_match_mask = 8'h00;
        cfg_post_cnt   = 4'd0;
        pulse_arm();
        flit(0, 8'h55, 1'b0);
        check("m0_ep0_no_trig", 32'(trigger), 32'd0);
        flit(2, 8'h3C, 1'b0);
        check("m0_trig", 32'(trigger), 32'd1);
        flit(2, 8'h44, 1'b0);
        check("pc0_done", 32'(state), 32'd3);
        pop_check("pc0_w0", 8'h3C);
        check("pc0_one_word", 32'(trace_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
